// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the data-memory bus for dmem_arbiter.
// master = environment (requesters + memory), slave = the arbiter itself.
interface dmem_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m0_err;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        m1_err;

  logic [1:0]  mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  mem_rw, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output mem_rw, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and 4-cycle access sequencer for the data memory.
// Optional out-of-range blocking: define DMEM_ARB_RANGE_CHECK_EN.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 80,
  parameter logic [31:0] PARK_ADDR = 32'hFFFF_FFF0
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {RW_NONE = 2'b00, RW_READ = 2'b01, RW_WRITE = 2'b10} rw_t;

  state_t state_q, state_d;
  rw_t    mem_rw_q, mem_rw_d;

  logic        port_q, port_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic        oor_q, oor_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic [1:0]  err_q, err_d;
  logic [1:0][31:0] rdata_q, rdata_d;

  logic [1:0]  req;
  logic        winner;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_in_win;
  logic        sel_oor;

  assign req = {bus.m1_req, bus.m0_req};

  // On a tie the port not served last wins; last_q resets to 1 so port 0 wins first.
  assign winner    = (req[0] && req[1]) ? ~last_q : req[1];
  assign sel_we    = winner ? bus.m1_we    : bus.m0_we;
  assign sel_addr  = winner ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = winner ? bus.m1_wdata : bus.m0_wdata;

  // 33-bit sum so a word straddling 32'hFFFF_FFFF counts as out of range.
  assign sel_in_win = ({1'b0, sel_addr} + 33'd3) < 33'(MEM_BYTES);

`ifdef DMEM_ARB_RANGE_CHECK_EN
  assign sel_oor = ~sel_in_win;
`else
  logic unused_range;
  assign unused_range = sel_in_win;
  assign sel_oor      = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    last_d      = last_q;
    we_d        = we_q;
    oor_d       = oor_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    err_d       = '0;
    rdata_d     = '0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          port_d         = winner;
          we_d           = sel_we;
          addr_d         = sel_addr;
          wdata_d        = sel_wdata;
          oor_d          = sel_oor;
          gnt_d[winner]  = 1'b1;
          state_d        = SETUP;
          if (!sel_oor) begin
            mem_rw_d    = sel_we ? RW_WRITE : RW_READ;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // Closing edge of ACCESS: memory write commits, read data is captured.
        rvalid_d[port_q] = 1'b1;
        err_d[port_q]    = oor_q;
        if (!we_q && !oor_q) rdata_d[port_q] = bus.mem_rdata;
        mem_rw_d   = RW_NONE;
        mem_addr_d = PARK_ADDR;
        state_d    = RESP;
      end
      RESP: begin
        last_d  = port_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      port_q      <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      oor_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_rw_q    <= RW_NONE;
      mem_addr_q  <= PARK_ADDR;
      mem_wdata_q <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      last_q      <= last_d;
      we_q        <= we_d;
      oor_q       <= oor_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.m0_gnt    = gnt_q[0];
  assign bus.m1_gnt    = gnt_q[1];
  assign bus.m0_rvalid = rvalid_q[0];
  assign bus.m1_rvalid = rvalid_q[1];
  assign bus.m0_err    = err_q[0];
  assign bus.m1_err    = err_q[1];
  assign bus.m0_rdata  = rdata_q[0];
  assign bus.m1_rdata  = rdata_q[1];
  assign bus.mem_rw    = mem_rw_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the single-cycle core's byte-addressed data memory. Shares the memory between the core load/store path (port 0) and a loader/debug port (port 1) with round-robin fairness. Drives the memory's 2-bit access code, address and write data, and returns registered read data with a per-transaction response pulse. Sits between the load/store unit, the loader, and the data memory.

## Interface
- MEM_BYTES, 80: memory size in bytes; the valid word window is addr+3 < MEM_BYTES.
- PARK_ADDR, 32'hFFFF_FFF0: address driven while not accessing; must be outside the memory window.
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, synchronous, active-high
- mN_req  in  1  request from port N (N = 0, 1); held with its command until mN_gnt
- mN_we  in  1  1 = word write, 0 = word read
- mN_addr  in  32  byte address
- mN_wdata  in  32  write data, little-endian
- mN_gnt  out  1  one-cycle pulse: command accepted, may be dropped
- mN_rvalid  out  1  one-cycle completion pulse, for reads and writes
- mN_rdata  out  32  read data, valid only with mN_rvalid on a read, else 0
- mN_err  out  1  out-of-range flag, qualified by mN_rvalid
- mem_rw  out  2  memory access code: 00 none, 01 read, 10 write
- mem_addr  out  32  memory byte address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data; combinational, updates only on an address change

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - With no request, stay in IDLE.
  - With any request, select the winner, latch its we/addr/wdata and port id, and go to SETUP.
- Arbitration:
  - One request: that port wins.
  - Both requests: the port not served last wins.
  - The last-served pointer resets to 1, so port 0 wins the first tie.
- SETUP:
  - Pulse gnt for the winner.
  - Drive mem_addr = latched addr and mem_rw = 01 (read) or 10 (write). The address change from PARK_ADDR refreshes mem_rdata.
  - Go to ACCESS.
- ACCESS:
  - Hold mem_rw, mem_addr and mem_wdata.
  - A write commits at the closing edge.
  - For a read, mem_rdata is captured into the response register at the closing edge.
  - Go to RESP.
- RESP:
  - Pulse rvalid (plus rdata/err) for the winner only.
  - Drive mem_rw = 00 and mem_addr = PARK_ADDR.
  - Update the last-served pointer and go to IDLE.
- The loser's request stays pending and is served in the next IDLE visit.
- Arithmetic: addresses are unsigned 32-bit. The range test uses a 33-bit addr+3 so that wrap near 32'hFFFF_FFFF is out of range.
- Reset mid-transaction:
  - FSM returns to IDLE; no gnt or rvalid is emitted for the aborted transaction.
  - mem_rw = 00 from the first post-reset cycle.
  - A write whose ACCESS edge coincides with rst is not guaranteed to commit.

## Timing
- Reset values: all gnt/rvalid/err = 0, all rdata = 0, mem_rw = 00, mem_addr = PARK_ADDR, mem_wdata = 0, pointer = 1.
- Request sampled in IDLE at cycle T: gnt at T+1 (SETUP), ACCESS at T+2, rvalid at T+3, IDLE at T+4.
- Throughput: one transaction per 4 cycles. Back-to-back requests from alternating ports each see 4-cycle spacing.
- All outputs are registered; none depend combinationally on the mN_* inputs.
- mN_req dropped before gnt is permitted only via rst; otherwise it is a protocol violation and the behaviour is undefined.

## Configuration
- DMEM_ARB_RANGE_CHECK_EN defined:
  - A transaction with addr+3 >= MEM_BYTES still gets gnt at T+1.
  - mem_rw stays 00 and mem_addr stays PARK_ADDR through SETUP/ACCESS, so no memory access occurs.
  - RESP at T+3 pulses rvalid with err = 1 and rdata = 0.
- DMEM_ARB_RANGE_CHECK_EN undefined:
  - err is tied 0.
  - Every transaction is issued to memory unchecked; out-of-range behaviour is the memory's.

## Test plan
- Reset, then idle 5 cycles -> mem_rw = 00, mem_addr = 32'hFFFF_FFF0, all gnt/rvalid = 0.
- Port 0 writes 32'hDEAD_BEEF @ addr 16, then reads 16 -> write: gnt T+1, mem_rw = 10 at T+1..T+2, rvalid T+3. Read: rdata = 32'hDEAD_BEEF with rvalid at T+3.
- Port 0 and port 1 request in the same cycle from reset, both reading addr 8 -> port 0 served first with rdata = 32'h0000_0064; port 1 gnt 4 cycles after port 0's gnt.
- Both ports hold requests continuously for 8 transactions -> grants alternate 0, 1, 0, 1…; no port is starved.
- Port 1 reads addr 78 with the macro on -> rvalid with err = 1, rdata = 0, mem_rw = 00 throughout. With the macro off -> err = 0 and mem_rw = 01 issued.
- rst asserted during the ACCESS of a port 0 read -> no m0_rvalid; FSM back in IDLE with mem_rw = 00 next cycle; a fresh request then completes in 4 cycles.
